pool_2: RTL and testbench
=========================

// Module: pool_2
// PURPOSE
//  Consumer of the conv_2 output BRAM (fm_bram_1). Per map: reads both rows-halves via ports a/b,
//  2x2/stride-2 max-pools 10x10 -> 5x5, optional ReLU, writes 25 lanes as one word to pool_bram.
//  Sits between conv_2 and the fc stage; started/finished with the same en/finish level handshake.
// PARAMETERS
//  N_MAPS  16  feature maps to process (map m at fm_bram_1 addr 2m / 2m+1, pool_bram addr m)
//  DW      16  lane width, signed two's complement
//  LANES   56  lanes per fm_bram_1 word (only 0..49 valid)
//  RD_LAT  2   fm_bram_1 read latency in cycles (en/addr edge -> dout valid), >=1
//  RELU    1   1: clamp negative pooled results to 0; 0: pass through
// PORTS
//  clk             in   1             clock, all logic on posedge
//  rst_n           in   1             asynchronous, active-low reset
//  pool_2_en       in   1             level enable; rising edge starts a pass; low aborts/clears
//  fm_bram_1_ena   out  1             port-a read enable
//  fm_bram_1_enb   out  1             port-b read enable
//  fm_bram_1_addra out  7             port-a address (2m)
//  fm_bram_1_addrb out  7             port-b address (2m+1)
//  fm_bram_1_douta in   LANES*DW      port-a data: rows 0-4 of map m
//  fm_bram_1_doutb in   LANES*DW      port-b data: rows 5-9 of map m
//  pool_bram_wea   out  1             write strobe, one cycle per map
//  pool_bram_addra out  4             write address = m
//  pool_bram_dina  out  25*DW         pooled 5x5 map, lane r*5+c
//  pool_2_finish   out  1             high after last write until pool_2_en falls
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, map counter m=0, row counter r=0, buffers 0.
//  Lane map in: douta lane k (bits k*DW+:DW), k<50 -> x[k/10][k%10]; doutb lane k -> x[5+k/10][k%10].
//   Lanes 50..LANES-1 ignored.
//  Start: en_d registers pool_2_en; start = pool_2_en & ~en_d, honoured only in IDLE (m<=0).
//  FSM:
//   IDLE  : start -> READ.
//   READ  : 1 cycle; ena=enb=1, addra=2m, addrb=2m+1 (registered, so visible this state) -> WAIT.
//   WAIT  : RD_LAT cycles counted from READ cycle; on final cycle capture both douts into
//           10x10 buffer -> POOL (r=0).
//   POOL  : 5 cycles, r=0..4: out[r][c]=max(x[2r][2c],x[2r][2c+1],x[2r+1][2c],x[2r+1][2c+1]),
//           c=0..4, signed compare; if RELU and result<0 -> 0; stored in dina lanes r*5+c.
//           r==4 -> WRITE.
//   WRITE : wea=1, addra=m, dina complete, 1 cycle. m==N_MAPS-1 -> DONE else m++ -> READ.
//   DONE  : pool_2_finish=1; stays until pool_2_en=0 -> IDLE, finish=0, m=0 next cycle.
//  ena/enb/wea are single-cycle pulses; low in every other state. dina held between writes.
//  Per map: 1+RD_LAT+5+1 cycles (9 at default); finish rises cycle after last wea;
//   total from start edge to finish = N_MAPS*(RD_LAT+7)+1 cycles (145 at defaults).
//  pool_2_en low in any non-IDLE state: next cycle FSM IDLE, m=0, strobes 0, no partial write.
//  Rising edge outside IDLE ignored. rst_n low mid-pass: immediate clear, re-run needs new edge.
//  Ties in max: any equal value (identical bits). No saturation: output is an input value or 0.
//  Address widths: 2m max 31 fits 7b; m fits 4b; N_MAPS>16 unsupported.
// TESTING
//  1 map m: x[i][j]=i*10+j (all positive), RELU=1 -> lane r*5+c = (2r+1)*10+2c+1, addr m, all 16 maps.
//  All inputs -5, RELU=1 -> every dina lane 0; RELU=0 -> every lane 0xFFFB.
//  Per 2x2 window one max at each corner position incl. 0x7FFF vs 0x8000 -> signed max chosen.
//  Timing: defaults, start edge at t0 -> ena pulse t0+1, wea pulses every 9 cycles, finish at t0+145.
//  Drop pool_2_en during map 3 POOL -> no wea for map 3 onward, finish stays 0; new edge restarts m=0.
//  Lanes 50..55 driven 0x7FFF -> no effect on output; rst_n pulse mid-WAIT -> all outputs 0 async.

Source files
------------

// File: rtl/pool_2.sv
// pool_2: 2x2 / stride-2 max-pool of 16 conv_2 feature maps (10x10 -> 5x5).
// Each map is read as two 56-lane words (rows 0-4 on port a, rows 5-9 on
// port b). One pooled output row is produced per cycle, optional ReLU is
// applied, and the finished 25-lane map is written as a single pool_bram word.
module pool_2 #(
  parameter int N_MAPS = 16,
  parameter int DW     = 16,
  parameter int LANES  = 56,
  parameter int RD_LAT = 2,
  parameter int RELU   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pool_2_en,
  output logic                  fm_bram_1_ena,
  output logic                  fm_bram_1_enb,
  output logic [6:0]            fm_bram_1_addra,
  output logic [6:0]            fm_bram_1_addrb,
  input  logic [LANES*DW-1:0]   fm_bram_1_douta,
  input  logic [LANES*DW-1:0]   fm_bram_1_doutb,
  output logic                  pool_bram_wea,
  output logic [3:0]            pool_bram_addra,
  output logic [25*DW-1:0]      pool_bram_dina,
  output logic                  pool_2_finish
);

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_POOL  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 en_d_q;
  logic [3:0]           m_q, m_d;
  logic [2:0]           r_q, r_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic                 start_s, cap_s, pool_s;

  logic                 ena_q, enb_q, wea_q, finish_q;
  logic [6:0]           addra_q, addrb_q;
  logic [3:0]           waddr_q;
  logic [25*DW-1:0]     stage_q, dina_q, dina_next_s;

  logic signed [DW-1:0] x_q [10][10];
  logic signed [DW-1:0] pool_row_s [5];
  logic [3:0]           row_a_s, row_b_s;

  // Lanes 50..LANES-1 of each read word carry no pixel data.
  if (LANES > 50) begin : g_unused
    logic unused_s;
    assign unused_s = ^{fm_bram_1_douta[LANES*DW-1:50*DW], fm_bram_1_doutb[LANES*DW-1:50*DW]};
  end

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  assign start_s = pool_2_en & ~en_d_q;

  // Next-state logic; dropping the enable outside IDLE abandons the pass.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    wcnt_d  = wcnt_q;
    cap_s   = 1'b0;
    pool_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = S_READ;
          m_d     = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        wcnt_d  = {WCW{1'b0}};
      end
      S_WAIT: begin
        if (wcnt_q == WCW'(RD_LAT - 1)) begin
          cap_s   = 1'b1;
          state_d = S_POOL;
          r_d     = 3'd0;
        end else begin
          wcnt_d  = wcnt_q + WCW'(1);
        end
      end
      S_POOL: begin
        pool_s = 1'b1;
        if (r_q == 3'd4) begin
          state_d = S_WRITE;
        end else begin
          r_d = r_q + 3'd1;
        end
      end
      S_WRITE: begin
        if (m_q == 4'(N_MAPS - 1)) begin
          state_d = S_DONE;
        end else begin
          m_d     = m_q + 4'd1;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if ((state_q != S_IDLE) && !pool_2_en) begin
      state_d = S_IDLE;
      m_d     = 4'd0;
      r_d     = 3'd0;
      wcnt_d  = {WCW{1'b0}};
      cap_s   = 1'b0;
      pool_s  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  assign row_a_s = {r_q, 1'b0};
  assign row_b_s = {r_q, 1'b1};

  // One pooled row per POOL cycle, merged into the staged output word.
  always_comb begin
    dina_next_s = stage_q;
    for (int c = 0; c < 5; c++) begin
      pool_row_s[c] = smax(smax(x_q[row_a_s][2*c], x_q[row_a_s][2*c+1]),
                           smax(x_q[row_b_s][2*c], x_q[row_b_s][2*c+1]));
      if ((RELU != 0) && (pool_row_s[c] < 0)) begin
        pool_row_s[c] = {DW{1'b0}};
      end else begin
        pool_row_s[c] = pool_row_s[c];
      end
      dina_next_s[(int'(r_q)*5 + c)*DW +: DW] = pool_row_s[c];
    end
  end

  // Control state: FSM, counters and the enable edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      // Held high so an enable still asserted across reset is not a new start.
      en_d_q  <= 1'b1;
      m_q     <= 4'd0;
      r_q     <= 3'd0;
      wcnt_q  <= {WCW{1'b0}};
    end else begin
      state_q <= state_d;
      en_d_q  <= pool_2_en;
      m_q     <= m_d;
      r_q     <= r_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Registered strobes/addresses, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q    <= 1'b0;
      enb_q    <= 1'b0;
      addra_q  <= 7'd0;
      addrb_q  <= 7'd0;
      wea_q    <= 1'b0;
      waddr_q  <= 4'd0;
      finish_q <= 1'b0;
    end else begin
      ena_q    <= (state_d == S_READ);
      enb_q    <= (state_d == S_READ);
      addra_q  <= (state_d == S_READ) ? {2'b00, m_d, 1'b0} : 7'd0;
      addrb_q  <= (state_d == S_READ) ? {2'b00, m_d, 1'b1} : 7'd0;
      wea_q    <= (state_d == S_WRITE);
      waddr_q  <= (state_d == S_WRITE) ? m_d : 4'd0;
      finish_q <= (state_d == S_DONE);
    end
  end

  // Datapath: 10x10 capture buffer, row staging and the held write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < 10; j++) begin
          x_q[i][j] <= {DW{1'b0}};
        end
      end
      stage_q <= {(25*DW){1'b0}};
      dina_q  <= {(25*DW){1'b0}};
    end else begin
      if (cap_s) begin
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 10; j++) begin
            x_q[i][j]   <= fm_bram_1_douta[(i*10+j)*DW +: DW];
            x_q[5+i][j] <= fm_bram_1_doutb[(i*10+j)*DW +: DW];
          end
        end
      end
      if (pool_s) begin
        stage_q <= dina_next_s;
      end
      // The output word only changes once the whole map is pooled.
      if (pool_s && (r_q == 3'd4)) begin
        dina_q <= dina_next_s;
      end
    end
  end

  assign fm_bram_1_ena   = ena_q;
  assign fm_bram_1_enb   = enb_q;
  assign fm_bram_1_addra = addra_q;
  assign fm_bram_1_addrb = addrb_q;
  assign pool_bram_wea   = wea_q;
  assign pool_bram_addra = waddr_q;
  assign pool_bram_dina  = dina_q;
  assign pool_2_finish   = finish_q;

endmodule

// File: tb/tb_pool_2.sv
// Scoreboard bench for pool_2: two instances (ReLU on/off) share one
// latency-accurate fm_bram_1 model; expected pool_bram words are queued when a
// pass is launched and checked by an independent monitor on every write.
module tb_pool_2;

  localparam int DW    = 16;
  localparam int LANES = 56;
  localparam int WW    = 25*DW;

  logic             clk, rst_n, en;
  logic             ena, enb, wea, finish;
  logic [6:0]       addra, addrb;
  logic [3:0]       waddr;
  logic [WW-1:0]    dina;
  logic             ena0, enb0, wea0, finish0;
  logic [6:0]       addra0, addrb0;
  logic [3:0]       waddr0;
  logic [WW-1:0]    dina0;
  logic [LANES*DW-1:0] douta, doutb;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;
  int mode  = 0;

  typedef struct {
    logic [3:0]    a;
    logic [WW-1:0] d1;
    logic [WW-1:0] d0;
  } exp_t;
  exp_t q[$];

  pool_2 #(.RELU(1)) dut (
    .clk(clk), .rst_n(rst_n), .pool_2_en(en),
    .fm_bram_1_ena(ena), .fm_bram_1_enb(enb),
    .fm_bram_1_addra(addra), .fm_bram_1_addrb(addrb),
    .fm_bram_1_douta(douta), .fm_bram_1_doutb(doutb),
    .pool_bram_wea(wea), .pool_bram_addra(waddr), .pool_bram_dina(dina),
    .pool_2_finish(finish)
  );

  pool_2 #(.RELU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pool_2_en(en),
    .fm_bram_1_ena(ena0), .fm_bram_1_enb(enb0),
    .fm_bram_1_addra(addra0), .fm_bram_1_addrb(addrb0),
    .fm_bram_1_douta(douta), .fm_bram_1_doutb(doutb),
    .pool_bram_wea(wea0), .pool_bram_addra(waddr0), .pool_bram_dina(dina0),
    .pool_2_finish(finish0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel x[i][j] of map m for each stimulus pattern.
  function automatic logic [15:0] px(input int md, input int m, input int i, input int j);
    int w, pos;
    w   = (i/2)*5 + (j/2);
    pos = (i%2)*2 + (j%2);
    case (md)
      0: return 16'(i*10 + j + m*100);
      1: return 16'hFFFB;
      2: begin
        if (w == 0)       return (pos == 0) ? 16'h7FFF : 16'h8000;
        else if (w == 24) return (pos == 0) ? 16'hFFFE : 16'hFED4;
        else              return (pos == w%4) ? 16'(w*3 + 1 + m) : 16'(w*3 + m);
      end
      default: return 16'h0000;
    endcase
  endfunction

  // Word stored at fm_bram_1 address a; 7F marks "not a valid read".
  function automatic logic [LANES*DW-1:0] mk_word(input logic [6:0] a, input int md);
    logic [LANES*DW-1:0] w;
    int base;
    base = a[0] ? 5 : 0;
    for (int k = 0; k < LANES; k++) begin
      if (a == 7'h7F)  w[k*DW +: DW] = 16'h4321;
      else if (k >= 50) w[k*DW +: DW] = 16'h7FFF;
      else             w[k*DW +: DW] = px(md, int'(a >> 1), base + k/10, k%10);
    end
    return w;
  endfunction

  // Hand-derived pooled value for lane l of map m.
  function automatic logic [15:0] exp_lane(input int md, input int m, input int l, input bit relu);
    int r, c;
    r = l / 5;
    c = l % 5;
    case (md)
      0: return 16'((2*r+1)*10 + 2*c + 1 + m*100);
      1: return relu ? 16'h0000 : 16'hFFFB;
      2: begin
        if (l == 0)       return 16'h7FFF;
        else if (l == 24) return relu ? 16'h0000 : 16'hFFFE;
        else              return 16'(l*3 + 1 + m);
      end
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [WW-1:0] exp_word(input int md, input int m, input bit relu);
    logic [WW-1:0] w;
    for (int l = 0; l < 25; l++) w[l*DW +: DW] = exp_lane(md, m, l, relu);
    return w;
  endfunction

  // fm_bram_1 model with a two-cycle read latency.
  logic [6:0] pa0 = 7'h7F, pa1 = 7'h7F, pb0 = 7'h7F, pb1 = 7'h7F;
  always @(posedge clk) begin
    pa0 <= ena ? addra : 7'h7F;
    pb0 <= enb ? addrb : 7'h7F;
    pa1 <= pa0;
    pb1 <= pb0;
  end
  always_comb douta = mk_word(pa1, mode);
  always_comb doutb = mk_word(pb1, mode);

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: read-pulse timing/addressing and every pool_bram write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ena) begin
        check("ena_time", WW'(cyc), WW'(t0 + 1 + 9*int'(addra >> 1)));
        check("addr_pair", {enb, addrb}, {1'b1, addra + 7'd1});
      end
      if (wea || wea0) begin
        if (q.size() == 0) begin
          check("unexpected_wea", {wea, waddr}, 5'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("waddr", {wea, wea0, waddr, waddr0}, {2'b11, e.a, e.a});
          check("dina_relu1", dina, e.d1);
          check("dina_relu0", dina0, e.d0);
          check("wea_time", WW'(cyc), WW'(t0 + 9 + 9*int'(e.a)));
        end
      end
    end
  end

  task automatic push_maps(input int md, input int n);
    exp_t e;
    for (int m = 0; m < n; m++) begin
      e.a  = 4'(m);
      e.d1 = exp_word(md, m, 1'b1);
      e.d0 = exp_word(md, m, 1'b0);
      q.push_back(e);
    end
  endtask

  task automatic start_pass(input int md);
    @(posedge clk);
    #1;
    mode = md;
    en   = 1'b1;
    t0   = cyc;
  endtask

  task automatic full_pass(input int md);
    int fin;
    push_maps(md, 16);
    start_pass(md);
    fin = -1;
    for (int i = 0; i < 400 && fin < 0; i++) begin
      @(negedge clk);
      if (finish) fin = cyc;
    end
    check("finish_time", WW'(fin), WW'(t0 + 145));
    check("all_writes_seen", WW'(q.size()), WW'(0));
    repeat (3) @(negedge clk);
    check("finish_hold", {finish, finish0}, 2'b11);
    @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("finish_clear", {finish, finish0, ena, wea}, 4'b0000);
  endtask

  initial begin
    bit saw;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ena, enb, addra, addrb, wea, waddr, finish, dina},
          {(WW+23){1'b0}});
    check("reset_outputs0", {ena0, enb0, addra0, addrb0, wea0, waddr0, finish0, dina0},
          {(WW+23){1'b0}});
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    full_pass(0);
    full_pass(1);
    full_pass(2);

    // Abort during map 3 pooling: only maps 0..2 may be written.
    push_maps(0, 3);
    start_pass(0);
    repeat (32) @(posedge clk);
    #1 en = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (finish || finish0) saw = 1'b1;
    end
    check("abort_no_finish", WW'(saw), WW'(0));
    check("abort_writes", WW'(q.size()), WW'(0));

    full_pass(0);

    // Reset pulse in WAIT: immediate clear, no restart without a new edge.
    start_pass(2);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {ena, enb, addra, addrb, wea, waddr, finish, dina},
          {(WW+23){1'b0}});
    @(posedge clk);
    #1 rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ena || wea || finish) saw = 1'b1;
    end
    check("no_restart_after_reset", WW'(saw), WW'(0));
    @(posedge clk);
    #1 en = 1'b0;
    repeat (2) @(posedge clk);
    full_pass(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
